bp_fe_bht_gshare: RTL and testbench
===================================

// Module: bp_fe_bht_gshare
// PURPOSE
//   Parametrised gshare branch history table for the FE: a table of N-bit saturating counters.
//   It is indexed by the PC index XOR a speculative global history register (GHR).
//   It predicts one cycle after a read request and trains on branch resolution from the BE.
//   It restores the GHR on mispredict and initialises the table by hardware sweep after reset.
// PARAMETERS
//   bht_idx_width_p  9  table index width; els = 2**bht_idx_width_p entries
//   ghist_width_p    4  GHR length; legal range 1..bht_idx_width_p
//   ctr_width_p      2  saturating counter width, >=1; MSB=1 means predict taken
//   ctr_init_p       2**(ctr_width_p-1)-1  value written to every entry during init (weak not-taken)
// PORTS
//   clk_i           in   1                clock
//   reset_n_i       in   1                asynchronous active-low reset
//   init_done_o     out  1                table sweep complete; reads/writes accepted only when 1
//   r_v_i           in   1                prediction request
//   r_idx_i         in   bht_idx_width_p  PC-derived index
//   pred_v_o        out  1                prediction valid; asserted one cycle after an accepted r_v_i
//   pred_taken_o    out  1                MSB of the selected counter
//   pred_idx_o      out  bht_idx_width_p  hashed index used; carried with the branch
//   pred_ghist_o    out  ghist_width_p    GHR value used for the hash; carried with the branch
//   spec_v_i        in   1                speculative history push, from the FE when it redirects on a prediction
//   spec_taken_i    in   1                direction pushed into the GHR
//   w_v_i           in   1                resolution/training request
//   w_idx_i         in   bht_idx_width_p  hashed index returned with the branch (pred_idx_o)
//   w_ghist_i       in   ghist_width_p    GHR snapshot returned with the branch (pred_ghist_o)
//   w_taken_i       in   1                resolved direction
//   w_mispredict_i  in   1                resolved direction differs from prediction
// BEHAVIOUR
// - Reset (async, reset_n_i=0):
//   - Outputs: init_done_o=0, pred_v_o=0, pred_taken_o=0, pred_idx_o=0, pred_ghist_o=0.
//   - State: GHR=0, sweep counter=0, FSM=INIT.
//   - Table contents are not reset by the async reset; they are rewritten by the sweep.
// - FSM INIT -> READY:
//   - INIT writes ctr_init_p to entry[sweep_cnt] and increments sweep_cnt, one entry per cycle.
//   - On the cycle sweep_cnt == els-1 is written, FSM moves to READY and init_done_o=1 on the next cycle.
//   - Total init: els cycles after reset release.
//   - In INIT, r_v_i, w_v_i and spec_v_i are ignored: no table write, no GHR change, pred_v_o stays 0.
// - Reset asserted mid-sweep or mid-operation: back to INIT; the sweep restarts from entry 0.
// - Hash: h = r_idx_i ^ {{(bht_idx_width_p-ghist_width_p){1'b0}}, GHR}.
//   - When ghist_width_p == bht_idx_width_p, there is no zero padding.
// - Read (READY, r_v_i=1):
//   - The next cycle gives pred_v_o=1, pred_taken_o=entry[h][ctr_width_p-1], pred_idx_o=h, and pred_ghist_o=GHR sampled at request.
//   - Prediction outputs are registered and hold their last value while pred_v_o=0.
// - Write (READY, w_v_i=1):
//   - entry[w_idx_i] is updated in the same edge.
//   - Taken: +1, saturating at 2**ctr_width_p-1.
//   - Not taken: -1, saturating at 0.
//   - No wrap in either direction.
// - GHR update, priority high to low:
//   - w_v_i & w_mispredict_i: GHR <= {w_ghist_i[ghist_width_p-2:0], w_taken_i}. For ghist_width_p==1, GHR <= w_taken_i. A concurrent spec_v_i is dropped.
//   - spec_v_i: GHR <= {GHR[ghist_width_p-2:0], spec_taken_i}.
//   - Otherwise: hold.
// - Same-cycle read and write to the same index: the read returns the pre-write counter value; there is no bypass.
// - Same-cycle read and GHR update: the hash uses the GHR before the update.
// - Back-to-back reads each cycle: a full-throughput stream with 1-cycle latency.
// TESTING
// 1. Release reset with els=512: init_done_o rises exactly 512 cycles later. Each entry then reads pred_taken_o=0 (ctr_init_p=1). r_v_i during the sweep -> pred_v_o stays 0.
// 2. Saturation: w_v_i, w_taken_i=1 x5 to idx 0x05 -> counter 3. Then 4 not-taken writes -> 0; a 5th stays 0. Predictions follow MSB (1,1,0,0 ...).
// 3. Hash/GHR: spec_v_i taken,taken,not,taken -> GHR=4'b1101. Read r_idx_i=0x100 -> pred_idx_o=0x10D, pred_ghist_o=4'hD.
// 4. Mispredict restore: GHR=4'hF, w_mispredict_i with w_ghist_i=4'h3, w_taken_i=0, plus spec_v_i in the same cycle -> GHR=4'h6; the spec push is lost.
// 5. Read and write to the same index in one cycle, counter=1, write taken -> pred_taken_o=0 (old value). A following read -> 1.
// 6. Assert reset_n_i during the sweep at entry 200 -> init_done_o drops immediately. After release, the full 512-cycle sweep repeats from entry 0.

Source files
------------

// File: rtl/bp_fe_bht_gshare.sv
// Gshare branch history table: saturating counters indexed by PC index XOR speculative GHR,
// registered prediction, training on resolution, GHR repair on mispredict, post-reset sweep.
module bp_fe_bht_gshare #(
    parameter int bht_idx_width_p = 9,
    parameter int ghist_width_p   = 4,
    parameter int ctr_width_p     = 2,
    parameter int ctr_init_p      = 2**(ctr_width_p-1)-1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    output logic                       init_done_o,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] r_idx_i,
    output logic                       pred_v_o,
    output logic                       pred_taken_o,
    output logic [bht_idx_width_p-1:0] pred_idx_o,
    output logic [ghist_width_p-1:0]   pred_ghist_o,
    input  logic                       spec_v_i,
    input  logic                       spec_taken_i,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] w_idx_i,
    input  logic [ghist_width_p-1:0]   w_ghist_i,
    input  logic                       w_taken_i,
    input  logic                       w_mispredict_i
);

    localparam int els_lp = 2**bht_idx_width_p;
    localparam logic [ctr_width_p-1:0]     ctr_init_lp = ctr_width_p'(ctr_init_p);
    localparam logic [ctr_width_p-1:0]     ctr_max_lp  = '1;
    localparam logic [ctr_width_p-1:0]     ctr_one_lp  = ctr_width_p'(1);
    localparam logic [bht_idx_width_p-1:0] idx_last_lp = '1;
    localparam logic [bht_idx_width_p-1:0] idx_one_lp  = bht_idx_width_p'(1);

    typedef enum logic {
        e_init,
        e_ready
    } state_e;

    state_e                       state_reg, state_next;
    logic [bht_idx_width_p-1:0]   sweep_cnt_reg, sweep_cnt_next;
    logic [ghist_width_p-1:0]     ghr_reg, ghr_next;

    logic                         pred_v_reg;
    logic                         pred_taken_reg;
    logic [bht_idx_width_p-1:0]   pred_idx_reg;
    logic [ghist_width_p-1:0]     pred_ghist_reg;

    // Counter storage is deliberately excluded from reset; the sweep rewrites it.
    logic [ctr_width_p-1:0]       mem [els_lp];

    logic                         ready;
    logic [bht_idx_width_p-1:0]   hash_idx;
    logic [ctr_width_p-1:0]       w_ctr;
    logic [ctr_width_p-1:0]       w_ctr_upd;
    logic                         mem_we;
    logic [bht_idx_width_p-1:0]   mem_waddr;
    logic [ctr_width_p-1:0]       mem_wdata;
    logic [ghist_width_p-1:0]     ghr_restore;
    logic [ghist_width_p-1:0]     ghr_spec;
    logic                         unused_ok;

    assign ready = (state_reg == e_ready);

    // Only the low ghist_width_p index bits are folded with history.
    genvar gi;
    generate
        for (gi = 0; gi < bht_idx_width_p; gi++) begin : g_hash
            if (gi < ghist_width_p) begin : g_xor
                assign hash_idx[gi] = r_idx_i[gi] ^ ghr_reg[gi];
            end else begin : g_pass
                assign hash_idx[gi] = r_idx_i[gi];
            end
        end

        if (ghist_width_p == 1) begin : g_ghr_one
            assign ghr_restore = w_taken_i;
            assign ghr_spec    = spec_taken_i;
            assign unused_ok   = ^{w_ghist_i, ghr_reg};
        end else begin : g_ghr_shift
            assign ghr_restore = {w_ghist_i[ghist_width_p-2:0], w_taken_i};
            assign ghr_spec    = {ghr_reg[ghist_width_p-2:0], spec_taken_i};
            assign unused_ok   = ^{w_ghist_i[ghist_width_p-1], ghr_reg[ghist_width_p-1]};
        end
    endgenerate

    assign w_ctr = mem[w_idx_i];

    always_comb begin
        w_ctr_upd = w_ctr;
        if (w_taken_i) begin
            if (w_ctr != ctr_max_lp) w_ctr_upd = w_ctr + ctr_one_lp;
        end else begin
            if (w_ctr != '0) w_ctr_upd = w_ctr - ctr_one_lp;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        ghr_next       = ghr_reg;
        mem_we         = 1'b0;
        mem_waddr      = w_idx_i;
        mem_wdata      = w_ctr_upd;
        if (state_reg == e_init) begin
            mem_we         = 1'b1;
            mem_waddr      = sweep_cnt_reg;
            mem_wdata      = ctr_init_lp;
            sweep_cnt_next = sweep_cnt_reg + idx_one_lp;
            if (sweep_cnt_reg == idx_last_lp) state_next = e_ready;
        end else begin
            mem_we = w_v_i;
            // Mispredict repair wins over a same-cycle speculative push.
            if (w_v_i && w_mispredict_i) ghr_next = ghr_restore;
            else if (spec_v_i)           ghr_next = ghr_spec;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg     <= e_init;
            sweep_cnt_reg <= '0;
            ghr_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
            ghr_reg       <= ghr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Read samples the pre-write counter and pre-update GHR of the same edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pred_v_reg     <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_idx_reg   <= '0;
            pred_ghist_reg <= '0;
        end else begin
            pred_v_reg <= r_v_i && ready;
            if (r_v_i && ready) begin
                pred_taken_reg <= mem[hash_idx][ctr_width_p-1];
                pred_idx_reg   <= hash_idx;
                pred_ghist_reg <= ghr_reg;
            end
        end
    end

    assign init_done_o  = ready;
    assign pred_v_o     = pred_v_reg;
    assign pred_taken_o = pred_taken_reg;
    assign pred_idx_o   = pred_idx_reg;
    assign pred_ghist_o = pred_ghist_reg;

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Randomized scoreboard bench for bp_fe_bht_gshare against an arithmetic table/history model.
module tb_bp_fe_bht_gshare;

    localparam int IDX_W = 9;
    localparam int GH_W  = 4;
    localparam int ELS   = 512;
    localparam int CMAX  = 3;
    localparam int CINIT = 1;
    localparam int GMASK = 15;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic             init_done_o;
    logic             r_v_i;
    logic [IDX_W-1:0] r_idx_i;
    logic             pred_v_o;
    logic             pred_taken_o;
    logic [IDX_W-1:0] pred_idx_o;
    logic [GH_W-1:0]  pred_ghist_o;
    logic             spec_v_i;
    logic             spec_taken_i;
    logic             w_v_i;
    logic [IDX_W-1:0] w_idx_i;
    logic [GH_W-1:0]  w_ghist_i;
    logic             w_taken_i;
    logic             w_mispredict_i;

    bp_fe_bht_gshare dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .init_done_o(init_done_o),
        .r_v_i(r_v_i), .r_idx_i(r_idx_i),
        .pred_v_o(pred_v_o), .pred_taken_o(pred_taken_o),
        .pred_idx_o(pred_idx_o), .pred_ghist_o(pred_ghist_o),
        .spec_v_i(spec_v_i), .spec_taken_i(spec_taken_i),
        .w_v_i(w_v_i), .w_idx_i(w_idx_i), .w_ghist_i(w_ghist_i),
        .w_taken_i(w_taken_i), .w_mispredict_i(w_mispredict_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int idx;
        int gh;
        int tk;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    int   ctr [ELS];
    int   ghr;
    bit   model_ready;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every DUT prediction must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (reset_n_i && pred_v_o) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pred cyc=%0d idx=%0h", cyc, pred_idx_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (pred_idx_o != e.idx[IDX_W-1:0] || pred_ghist_o != e.gh[GH_W-1:0] ||
                    pred_taken_o != e.tk[0] || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL pred actual idx=%0h gh=%0h tk=%0d cyc=%0d required idx=%0h gh=%0h tk=%0d cyc=%0d",
                             pred_idx_o, pred_ghist_o, pred_taken_o, cyc, e.idx, e.gh, e.tk, e.cyc);
                end else begin
                    $display("pred ok idx=%0h gh=%0h tk=%0d", e.idx, e.gh, e.tk);
                end
            end
        end
    end

    task automatic step(input bit rv, input int ridx, input bit sv, input bit st,
                        input bit wv, input int widx, input int wgh, input bit wt, input bit wm);
        exp_t e;
        int   h;
        r_v_i = rv; r_idx_i = ridx[IDX_W-1:0];
        spec_v_i = sv; spec_taken_i = st;
        w_v_i = wv; w_idx_i = widx[IDX_W-1:0]; w_ghist_i = wgh[GH_W-1:0];
        w_taken_i = wt; w_mispredict_i = wm;
        if (model_ready) begin
            if (rv) begin
                h = ridx ^ ghr;
                e.idx = h; e.gh = ghr; e.tk = (ctr[h] >= 2) ? 1 : 0; e.cyc = cyc + 1;
                q.push_back(e);
            end
            if (wv) begin
                if (wt) ctr[widx] = (ctr[widx] < CMAX) ? ctr[widx] + 1 : CMAX;
                else    ctr[widx] = (ctr[widx] > 0) ? ctr[widx] - 1 : 0;
            end
            if (wv && wm)  ghr = ((wgh << 1) | int'(wt)) & GMASK;
            else if (sv)   ghr = ((ghr << 1) | int'(st)) & GMASK;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_step();
        step($urandom_range(0, 1), $urandom_range(0, ELS - 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
             $urandom_range(0, GMASK), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
    endtask

    // Counts edges from release until init_done_o, with random traffic that must be ignored.
    task automatic sweep(input string name);
        int n = 0;
        model_ready = 0;
        while (!init_done_o && n < 600) begin
            rand_step();
            n++;
        end
        chk(name, n, ELS);
        for (int i = 0; i < ELS; i++) ctr[i] = CINIT;
        ghr = 0;
        model_ready = 1;
    endtask

    task automatic read_all();
        for (int i = 0; i < ELS; i++) step(1, i, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
    endtask

    initial begin
        reset_n_i = 1'b0;
        model_ready = 0;
        ghr = 0;
        r_v_i = 0; r_idx_i = '0; spec_v_i = 0; spec_taken_i = 0;
        w_v_i = 0; w_idx_i = '0; w_ghist_i = '0; w_taken_i = 0; w_mispredict_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_init_done", int'(init_done_o), 0);
        chk("rst_pred_v", int'(pred_v_o), 0);
        chk("rst_pred_taken", int'(pred_taken_o), 0);
        chk("rst_pred_idx", int'(pred_idx_o), 0);
        chk("rst_pred_ghist", int'(pred_ghist_o), 0);
        reset_n_i = 1'b1;
        sweep("init_cycles");
        read_all();

        // Saturation up and down on entry 5 (GHR is 0 so r_idx maps directly).
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 5, 0, 1, 0);
            step(1, 5, 0, 0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 5, 0, 0, 0);
            step(1, 5, 0, 0, 0, 0, 0, 0, 0);
        end

        // Speculative history t,t,n,t then hashed read of 0x100.
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 'h100, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        chk("hash_ghr_model", ghr, 'hD);

        // GHR to F, then mispredict repair with a competing spec push.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 'h40, 3, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Same-cycle read and taken-write on entry 0x20 (counter 1): old value then new.
        step(1, 'h20 ^ ghr, 0, 0, 1, 'h20, 0, 1, 0);
        step(1, 'h20 ^ ghr, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 2000; i++) rand_step();
        idle(3);

        // Reset during operation: init_done must fall without waiting for an edge.
        reset_n_i = 1'b0;
        #1;
        chk("midop_init_done", int'(init_done_o), 0);
        chk("midop_pred_v", int'(pred_v_o), 0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        model_ready = 0;
        for (int i = 0; i < 200; i++) rand_step();
        chk("midsweep_init_done", int'(init_done_o), 0);
        reset_n_i = 1'b0;
        #1;
        chk("midsweep_rst_init_done", int'(init_done_o), 0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        sweep("resweep_cycles");
        read_all();
        for (int i = 0; i < 300; i++) rand_step();
        idle(3);

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
